// File: rtl/pong_vga_renderer_pkg.sv
// Shared geometry and timing defaults for the game logic and the VGA renderer,
// plus the game-state snapshot record and an 11-bit half-open range helper.
package pong_vga_renderer_pkg;

   localparam int unsigned H_VISIBLE_DEF    = 640;
   localparam int unsigned H_FRONT_DEF      = 16;
   localparam int unsigned H_SYNC_DEF       = 96;
   localparam int unsigned H_BACK_DEF       = 48;
   localparam int unsigned V_VISIBLE_DEF    = 480;
   localparam int unsigned V_FRONT_DEF      = 10;
   localparam int unsigned V_SYNC_DEF       = 2;
   localparam int unsigned V_BACK_DEF       = 33;
   localparam int unsigned PAD_WIDTH_DEF    = 8;
   localparam int unsigned PAD_HEIGHT_DEF   = 64;
   localparam int unsigned PAD_DISTANCE_DEF = 16;
   localparam int unsigned BALL_SIZE_DEF    = 8;

   typedef struct packed {
      logic [9:0] pad_left;
      logic [9:0] pad_right;
      logic [9:0] ball_x;
      logic [8:0] ball_y;
   } game_state_t;

   // 11-bit compare so objects near the edge clip instead of wrapping to 0
   function automatic logic in_span(input logic [10:0] pos,
                                    input logic [10:0] lo,
                                    input logic [10:0] len);
      return (pos >= lo) && (pos < lo + len);
   endfunction

endpackage

// File: rtl/pong_vga_renderer_if.sv
// Game-state interface: game logic (master) drives pad and ball positions,
// the renderer (slave) samples them once per frame.
interface pong_vga_renderer_if;
   logic [9:0] pad_left;
   logic [9:0] pad_right;
   logic [9:0] ball_x;
   logic [8:0] ball_y;

   modport master (output pad_left, pad_right, ball_x, ball_y);
   modport slave  (input  pad_left, pad_right, ball_x, ball_y);
endinterface

// File: rtl/pong_vga_renderer_vga_timing.sv
// VGA raster counters with raw (unregistered) sync, visible flag and a
// frame_end strobe for the last pixel of the last line.
module pong_vga_renderer_vga_timing #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_ce_i,
   output logic [9:0] hcnt_o,
   output logic [9:0] vcnt_o,
   output logic       hsync_raw_o,
   output logic       vsync_raw_o,
   output logic       visible_o,
   output logic       frame_end_o
);
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pix_ce_i) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hcnt_o      = hcnt_q;
   assign vcnt_o      = vcnt_q;
   assign hsync_raw_o = !((hcnt_q >= 10'(H_VISIBLE + H_FRONT)) &&
                          (hcnt_q <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
   assign vsync_raw_o = !((vcnt_q >= 10'(V_VISIBLE + V_FRONT)) &&
                          (vcnt_q <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
   assign visible_o   = (hcnt_q < 10'(H_VISIBLE)) && (vcnt_q < 10'(V_VISIBLE));
   assign frame_end_o = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: per-frame game-state snapshot, object hit tests and a
// registered sync/RGB stage. Define CENTER_NET_EN to draw the dashed centre net.
module pong_vga_renderer
   import pong_vga_renderer_pkg::*;
#(
   parameter int unsigned H_VISIBLE    = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT      = H_FRONT_DEF,
   parameter int unsigned H_SYNC       = H_SYNC_DEF,
   parameter int unsigned H_BACK       = H_BACK_DEF,
   parameter int unsigned V_VISIBLE    = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT      = V_FRONT_DEF,
   parameter int unsigned V_SYNC       = V_SYNC_DEF,
   parameter int unsigned V_BACK       = V_BACK_DEF,
   parameter int unsigned PAD_WIDTH    = PAD_WIDTH_DEF,
   parameter int unsigned PAD_HEIGHT   = PAD_HEIGHT_DEF,
   parameter int unsigned PAD_DISTANCE = PAD_DISTANCE_DEF,
   parameter int unsigned BALL_SIZE    = BALL_SIZE_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_ce,
   pong_vga_renderer_if.slave  gs,
   output logic                hsync,
   output logic                vsync,
   output logic [2:0]          rgb,
   output logic                frame_tick
);
   logic [9:0]  hcnt, vcnt;
   logic        hsync_raw, vsync_raw, visible, frame_end;
   logic [10:0] h11, v11;
   logic        lpad_hit, rpad_hit, ball_hit, net_hit;
   logic [2:0]  rgb_d;
   logic        hsync_q, vsync_q;
   logic [2:0]  rgb_q;
   game_state_t snap_q, snap_d;

   pong_vga_renderer_vga_timing #(
      .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .pix_ce_i    (pix_ce),
      .hcnt_o      (hcnt),
      .vcnt_o      (vcnt),
      .hsync_raw_o (hsync_raw),
      .vsync_raw_o (vsync_raw),
      .visible_o   (visible),
      .frame_end_o (frame_end)
   );

   always_comb begin
      h11      = {1'b0, hcnt};
      v11      = {1'b0, vcnt};
      lpad_hit = in_span(h11, 11'(PAD_DISTANCE), 11'(PAD_WIDTH)) &&
                 in_span(v11, {1'b0, snap_q.pad_left}, 11'(PAD_HEIGHT));
      rpad_hit = in_span(h11, 11'(H_VISIBLE - PAD_DISTANCE - PAD_WIDTH), 11'(PAD_WIDTH)) &&
                 in_span(v11, {1'b0, snap_q.pad_right}, 11'(PAD_HEIGHT));
      ball_hit = in_span(h11, {1'b0, snap_q.ball_x}, 11'(BALL_SIZE)) &&
                 in_span(v11, {2'b00, snap_q.ball_y}, 11'(BALL_SIZE));
`ifdef CENTER_NET_EN
      net_hit  = in_span(h11, 11'(H_VISIBLE / 2 - 2), 11'd4) && !vcnt[4];
`else
      net_hit  = 1'b0;
`endif
      rgb_d    = (visible && (lpad_hit || rpad_hit || ball_hit || net_hit)) ? '1 : '0;
   end

   // Snapshot loads on the edge that wraps to (0,0), so a whole frame sees one state
   always_comb begin
      snap_d = snap_q;
      if (frame_end) begin
         snap_d.pad_left  = gs.pad_left;
         snap_d.pad_right = gs.pad_right;
         snap_d.ball_x    = gs.ball_x;
         snap_d.ball_y    = gs.ball_y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
         snap_q  <= '0;
      end else if (pix_ce) begin
         hsync_q <= hsync_raw;
         vsync_q <= vsync_raw;
         rgb_q   <= rgb_d;
         snap_q  <= snap_d;
      end
   end

   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign rgb        = rgb_q;
   assign frame_tick = pix_ce && frame_end;

endmodule
